serial_audio_rx: RTL and testbench

Parametrised serial audio receiver for the capture path: it deserialises a bit-clock/word-select/data stream from a sound chip into parallel samples. It supports left-justified framing (the 054539 native format) and I2S framing, stereo or TDM channel counts, and a configurable word width. Samples are tagged with a channel index and buffered in a FIFO with a valid/ready handshake. It sits between the GPIO pins and the UART/packetiser and runs on the 32 MHz PLL clock.

---
 rtl/serial_audio_rx.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_serial_audio_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_audio_rx.sv
// serial_audio_rx
// ---------------------------------------------------------------------------
// Capture-path serial audio receiver. Deserialises a bit-clock / word-select /
// data stream from a sound chip into parallel samples tagged with a channel
// index, and buffers them in a show-ahead FIFO with a valid/ready handshake.
// Supports left-justified (MODE 0) and I2S (MODE 1) framing, stereo
// (CHANNELS = 2, WS level selects the channel) or TDM (CHANNELS > 2, a WS
// rising edge marks slot 0).
//
// Ports
//   clk          system clock (32 MHz PLL)
//   nreset       asynchronous active-low reset
//   en           capture enable; low forces the aligner back to unlocked
//   clear_flags  single-cycle pulse clearing overflow / frame_err
//   sck, ws, sd  asynchronous serial pins, synchronised internally
//   out_data     head sample, MSB-first assembled
//   out_chan     channel index of out_data
//   out_valid    FIFO head valid
//   out_ready    consumer accepts the head this cycle
//   fill         FIFO occupancy (0..DEPTH)
//   locked       aligned to a slot boundary
//   overflow     sticky: a completed sample was dropped on a full FIFO
//   frame_err    sticky: a slot ended with fewer than WIDTH bits
// ---------------------------------------------------------------------------
module serial_audio_rx #(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 2,
  parameter int  MODE     = 0,
  parameter int  DEPTH    = 16,
  localparam int CW       = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS),
  localparam int FW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             clear_flags,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FW-1:0]    fill,
  output logic             locked,
  output logic             overflow,
  output logic             frame_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = $clog2(WIDTH + 1);
  localparam int EW  = CW + WIDTH;
  localparam bit TDM = (CHANNELS > 2);

  // -------------------------------------------------------------------------
  // Pin synchronisers and sck rise detection
  // -------------------------------------------------------------------------
  logic sck_s1_reg, sck_s2_reg, sck_hist_reg;
  logic ws_s1_reg, ws_s2_reg;
  logic sd_s1_reg, sd_s2_reg;
  logic srise;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sck_s1_reg   <= 1'b0;
      sck_s2_reg   <= 1'b0;
      sck_hist_reg <= 1'b0;
      ws_s1_reg    <= 1'b0;
      ws_s2_reg    <= 1'b0;
      sd_s1_reg    <= 1'b0;
      sd_s2_reg    <= 1'b0;
    end else begin
      sck_s1_reg   <= sck;
      sck_s2_reg   <= sck_s1_reg;
      sck_hist_reg <= sck_s2_reg;
      ws_s1_reg    <= ws;
      ws_s2_reg    <= ws_s1_reg;
      sd_s1_reg    <= sd;
      sd_s2_reg    <= sd_s1_reg;
    end
  end

  assign srise = sck_s2_reg & ~sck_hist_reg;

  // -------------------------------------------------------------------------
  // Effective word select. In I2S the MSB trails the WS change by one bit
  // clock, so WS is delayed by one srise to line the slot start up with it.
  // ws_last_reg holds ws_eff as seen at the previous srise and keeps tracking
  // even while disabled, so enabling mid-stream does not fake a slot start.
  // -------------------------------------------------------------------------
  logic ws_prev_reg, ws_last_reg;
  logic ws_eff, ws_change, ws_rise;

  assign ws_eff    = (MODE == 1) ? ws_prev_reg : ws_s2_reg;
  assign ws_change = ws_eff ^ ws_last_reg;
  assign ws_rise   = ws_eff & ~ws_last_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ws_prev_reg <= 1'b0;
      ws_last_reg <= 1'b0;
    end else if (srise) begin
      ws_prev_reg <= ws_s2_reg;
      ws_last_reg <= ws_eff;
    end
  end

  // -------------------------------------------------------------------------
  // Slot aligner / deserialiser FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    bitcnt_reg, bitcnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    chan_reg, chan_next;
  logic             push_reg, push_next;
  logic [EW-1:0]    push_entry_reg, push_entry_next;
  logic             ferr_set;
  logic             slot_start;
  logic [CW-1:0]    slot_chan;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    cnt_after;

  // In TDM a slot also ends by count: the srise after WIDTH captured bits is
  // the first bit of the next slot. That only makes sense once aligned.
  always_comb begin
    if (!TDM) begin
      slot_start = ws_change;
    end else begin
      slot_start = ws_rise |
                   ((state_reg == ST_LOCKED) && (bitcnt_reg == BW'(WIDTH)));
    end
  end

  always_comb begin
    slot_chan = chan_reg;
    if (!TDM) begin
      slot_chan = CW'(ws_eff);
    end else if (ws_rise) begin
      slot_chan = '0;
    end else if (chan_reg == CW'(CHANNELS - 1)) begin
      slot_chan = '0;
    end else begin
      slot_chan = chan_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bitcnt_next     = bitcnt_reg;
    shift_next      = shift_reg;
    chan_next       = chan_reg;
    push_next       = 1'b0;
    push_entry_next = push_entry_reg;
    ferr_set        = 1'b0;
    // Older bits fall off the top; after WIDTH shifts only this slot remains.
    shifted         = (shift_reg << 1) | WIDTH'(sd_s2_reg);
    cnt_after       = bitcnt_reg + 1'b1;

    if (!en) begin
      // Partial word is abandoned; queued samples are untouched.
      state_next  = ST_UNLOCKED;
      bitcnt_next = '0;
    end else if (srise) begin
      if (slot_start) begin
        if ((bitcnt_reg != '0) && (bitcnt_reg < BW'(WIDTH))) begin
          ferr_set = 1'b1;
        end
        state_next  = ST_LOCKED;
        shift_next  = shifted;
        bitcnt_next = BW'(1);
        chan_next   = slot_chan;
        if (WIDTH == 1) begin
          push_next       = 1'b1;
          push_entry_next = {slot_chan, shifted};
        end
      end else if ((state_reg == ST_LOCKED) && (bitcnt_reg < BW'(WIDTH))) begin
        shift_next  = shifted;
        bitcnt_next = cnt_after;
        if (cnt_after == BW'(WIDTH)) begin
          push_next       = 1'b1;
          push_entry_next = {chan_reg, shifted};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg      <= ST_UNLOCKED;
      bitcnt_reg     <= '0;
      shift_reg      <= '0;
      chan_reg       <= '0;
      push_reg       <= 1'b0;
      push_entry_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bitcnt_reg     <= bitcnt_next;
      shift_reg      <= shift_next;
      chan_reg       <= chan_next;
      push_reg       <= push_next;
      push_entry_reg <= push_entry_next;
    end
  end

  assign locked = (state_reg == ST_LOCKED);

  // -------------------------------------------------------------------------
  // Show-ahead FIFO. The completed word is registered once (push_reg) before
  // being written, so a push into an empty FIFO shows up a cycle later.
  // -------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FW-1:0] fill_reg;
  logic [EW-1:0] head;
  logic          pop, push_ok, ovf_set;

  assign out_valid = (fill_reg != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_reg & ((fill_reg < FW'(DEPTH)) | pop);
  assign ovf_set   = push_reg & ~push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_entry_reg;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // Head is masked while empty so the outputs read zero out of reset.
  assign head     = mem[rd_ptr_reg];
  assign out_data = out_valid ? head[WIDTH-1:0] : '0;
  assign out_chan = out_valid ? head[EW-1:WIDTH] : '0;
  assign fill     = fill_reg;

  // -------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as clear_flags wins.
  // -------------------------------------------------------------------------
  logic overflow_reg, frame_err_reg;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (clear_flags) begin
        overflow_reg <= 1'b0;
      end
      if (ferr_set) begin
        frame_err_reg <= 1'b1;
      end else if (clear_flags) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_serial_audio_rx.sv
// Bench for serial_audio_rx. Four instances share the serial pins; each test
// enables only the instance(s) it targets. Expected samples are queued when
// the stimulus is driven and compared when each FIFO head is accepted.
module tb_serial_audio_rx;

  localparam int HALF = 5;  // sck half period in clk cycles

  logic clk = 1'b0;
  logic nreset, clear_flags, sck, ws, sd;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_lj[$], q_i2s[$], q_tdm[$], q_sm[$];

  // left-justified stereo, DEPTH 16
  logic en_lj, ready_lj, valid_lj, locked_lj, ovf_lj, ferr_lj, chan_lj;
  logic [15:0] data_lj;
  logic [4:0]  fill_lj;
  // I2S stereo, DEPTH 16
  logic en_i2s, ready_i2s, valid_i2s, locked_i2s, ovf_i2s, ferr_i2s, chan_i2s;
  logic [15:0] data_i2s;
  logic [4:0]  fill_i2s;
  // TDM 4 channels
  logic en_tdm, ready_tdm, valid_tdm, locked_tdm, ovf_tdm, ferr_tdm;
  logic [1:0]  chan_tdm;
  logic [15:0] data_tdm;
  logic [4:0]  fill_tdm;
  // left-justified stereo, DEPTH 4
  logic en_sm, ready_sm, valid_sm, locked_sm, ovf_sm, ferr_sm, chan_sm;
  logic [15:0] data_sm;
  logic [2:0]  fill_sm;

  serial_audio_rx #(.WIDTH(16), .CHANNELS(2), .MODE(0), .DEPTH(16)) u_lj (
    .clk(clk), .nreset(nreset), .en(en_lj), .clear_flags(clear_flags),
    .sck(sck), .ws(ws), .sd(sd), .out_data(data_lj), .out_chan(chan_lj),
    .out_valid(valid_lj), .out_ready(ready_lj), .fill(fill_lj),
    .locked(locked_lj), .overflow(ovf_lj), .frame_err(ferr_lj));

  serial_audio_rx #(.WIDTH(16), .CHANNELS(2), .MODE(1), .DEPTH(16)) u_i2s (
    .clk(clk), .nreset(nreset), .en(en_i2s), .clear_flags(clear_flags),
    .sck(sck), .ws(ws), .sd(sd), .out_data(data_i2s), .out_chan(chan_i2s),
    .out_valid(valid_i2s), .out_ready(ready_i2s), .fill(fill_i2s),
    .locked(locked_i2s), .overflow(ovf_i2s), .frame_err(ferr_i2s));

  serial_audio_rx #(.WIDTH(16), .CHANNELS(4), .MODE(0), .DEPTH(16)) u_tdm (
    .clk(clk), .nreset(nreset), .en(en_tdm), .clear_flags(clear_flags),
    .sck(sck), .ws(ws), .sd(sd), .out_data(data_tdm), .out_chan(chan_tdm),
    .out_valid(valid_tdm), .out_ready(ready_tdm), .fill(fill_tdm),
    .locked(locked_tdm), .overflow(ovf_tdm), .frame_err(ferr_tdm));

  serial_audio_rx #(.WIDTH(16), .CHANNELS(2), .MODE(0), .DEPTH(4)) u_sm (
    .clk(clk), .nreset(nreset), .en(en_sm), .clear_flags(clear_flags),
    .sck(sck), .ws(ws), .sd(sd), .out_data(data_sm), .out_chan(chan_sm),
    .out_valid(valid_sm), .out_ready(ready_sm), .fill(fill_sm),
    .locked(locked_sm), .overflow(ovf_sm), .frame_err(ferr_sm));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int ch, input logic [15:0] d);
    return (32'(ch) << 16) | {16'h0, d};
  endfunction

  function automatic logic [15:0] word_of(input int i);
    logic [3:0] v;
    v = i[3:0];
    return {v[3], 12'd0, v[2:0]};
  endfunction

  // ---------------- scoreboard monitors (sampled on the falling edge) -------
  always @(negedge clk) begin
    if (nreset && valid_lj && ready_lj) begin
      if (q_lj.size() == 0) check("lj_extra_pop", q_lj.size(), 1);
      else check("lj_sample", {15'd0, chan_lj, data_lj}, q_lj.pop_front());
      $display("pop lj chan=%0d data=%h", chan_lj, data_lj);
    end
    if (nreset && valid_i2s && ready_i2s) begin
      if (q_i2s.size() == 0) check("i2s_extra_pop", q_i2s.size(), 1);
      else check("i2s_sample", {15'd0, chan_i2s, data_i2s}, q_i2s.pop_front());
      $display("pop i2s chan=%0d data=%h", chan_i2s, data_i2s);
    end
    if (nreset && valid_tdm && ready_tdm) begin
      if (q_tdm.size() == 0) check("tdm_extra_pop", q_tdm.size(), 1);
      else check("tdm_sample", {14'd0, chan_tdm, data_tdm}, q_tdm.pop_front());
      $display("pop tdm chan=%0d data=%h", chan_tdm, data_tdm);
    end
    if (nreset && valid_sm && ready_sm) begin
      if (q_sm.size() == 0) check("sm_extra_pop", q_sm.size(), 1);
      else check("sm_sample", {15'd0, chan_sm, data_sm}, q_sm.pop_front());
      $display("pop sm chan=%0d data=%h", chan_sm, data_sm);
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  // Data and WS change with the falling sck, sampled on the rising sck.
  task automatic send_bit(input logic b, input logic w);
    sck = 1'b0;
    ws  = w;
    sd  = b;
    repeat (HALF) @(posedge clk);
    #1 sck = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic lvl, input int nbits);
    for (int b = 15; b > 15 - nbits; b--) send_bit(w[b], lvl);
  endtask

  task automatic idle(input int n, input logic lvl);
    for (int k = 0; k < n; k++) send_bit(1'b0, lvl);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    logic lvl, prev_bit;
    logic [15:0] w;

    nreset = 1'b0; clear_flags = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    en_lj = 0; en_i2s = 0; en_tdm = 0; en_sm = 0;
    ready_lj = 0; ready_i2s = 0; ready_tdm = 0; ready_sm = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_lj, 0);
    check("rst_fill", fill_lj, 0);
    check("rst_locked", locked_lj, 0);
    check("rst_flags", {ovf_lj, ferr_lj}, 0);
    check("rst_data", {chan_lj, data_lj}, 0);
    nreset = 1'b1;

    // ---- 1: left-justified stereo, FIFO filled to exactly DEPTH ----------
    idle(3, 1'b0);
    en_lj = 1;
    idle(2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      lvl = ~i[0];
      q_lj.push_back(pack(int'(lvl), word_of(i)));
      send_word(word_of(i), lvl, 16);
      if (i == 0) check("lj_locked", locked_lj, 1);
    end
    idle(2, 1'b0);
    settle();
    check("lj_fill_full", fill_lj, 16);
    check("lj_valid", valid_lj, 1);
    check("lj_flags", {ovf_lj, ferr_lj}, 0);
    ready_lj = 1;
    for (int k = 0; k < 300 && fill_lj != 0; k++) @(posedge clk);
    #1 check("lj_drain_fill", fill_lj, 0);
    en_lj = 0;

    // ---- 2: I2S stream into both the I2S and left-justified receivers -----
    idle(3, 1'b0);
    en_lj = 1; en_i2s = 1; ready_i2s = 1;
    idle(2, 1'b0);
    send_bit(1'b0, 1'b1);  // WS leads word 0 by one bit clock
    for (int i = 0; i < 16; i++) begin
      lvl = ~i[0];
      w = word_of(i);
      if (i == 0) prev_bit = 1'b0;
      else        prev_bit = word_of(i - 1) & 16'h1;
      q_i2s.push_back(pack(int'(lvl), w));
      q_lj.push_back(pack(int'(lvl), {prev_bit, w[15:1]}));
      send_word(w, lvl, 15);
      send_bit(w[0], (i == 15) ? lvl : ~lvl);
    end
    idle(2, 1'b0);
    settle();
    check("i2s_flags", {ovf_i2s, ferr_i2s}, 0);
    check("lj_on_i2s_flags", {ovf_lj, ferr_lj}, 0);
    check("i2s_sb_empty", q_i2s.size(), 0);
    en_lj = 0; en_i2s = 0;

    // ---- 3: TDM 4 slots, then a WS pulse arriving early -------------------
    idle(3, 1'b0);
    en_tdm = 1; ready_tdm = 1;
    idle(2, 1'b0);
    for (int s = 0; s < 4; s++) begin
      q_tdm.push_back(pack(s, 16'hA001 + 16'(s)));
      for (int b = 15; b >= 0; b--) begin
        w = 16'hA001 + 16'(s);
        send_bit(w[b], (s == 0) && (b == 15));
      end
    end
    check("tdm_ferr_clean", ferr_tdm, 0);
    q_tdm.push_back(pack(0, 16'hA001));
    w = 16'hA001;
    for (int b = 15; b >= 0; b--) send_bit(w[b], b == 15);
    w = 16'hA002;
    for (int b = 15; b >= 8; b--) send_bit(w[b], 1'b0);
    for (int s = 0; s < 4; s++) begin
      q_tdm.push_back(pack(s, 16'hB001 + 16'(s)));
      for (int b = 15; b >= 0; b--) begin
        w = 16'hB001 + 16'(s);
        send_bit(w[b], (s == 0) && (b == 15));
      end
    end
    en_tdm = 0;
    settle();
    check("tdm_ferr_set", ferr_tdm, 1);
    pulse_clear();
    #1 check("tdm_ferr_cleared", ferr_tdm, 0);
    check("tdm_sb_empty", q_tdm.size(), 0);

    // ---- 4: stereo short slot ---------------------------------------------
    idle(3, 1'b0);
    en_lj = 1;
    idle(2, 1'b0);
    send_word(16'h1234, 1'b1, 10);
    q_lj.push_back(pack(0, 16'h5678));
    send_word(16'h5678, 1'b0, 16);
    q_lj.push_back(pack(1, 16'h9ABC));
    send_word(16'h9ABC, 1'b1, 16);
    idle(2, 1'b1);
    settle();
    check("lj_ferr_set", ferr_lj, 1);
    check("lj_sb_empty", q_lj.size(), 0);
    pulse_clear();
    #1 check("lj_ferr_cleared", ferr_lj, 0);
    en_lj = 0;

    // ---- 5: DEPTH 4 overflow ----------------------------------------------
    idle(3, 1'b1);
    en_sm = 1;
    idle(2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      lvl = i[0];
      if (i < 4) q_sm.push_back(pack(int'(lvl), 16'hC000 + 16'(i)));
      send_word(16'hC000 + 16'(i), lvl, 16);
    end
    idle(2, 1'b1);
    settle();
    check("sm_fill_full", fill_sm, 4);
    check("sm_overflow", ovf_sm, 1);
    ready_sm = 1;
    for (int k = 0; k < 100 && fill_sm != 0; k++) @(posedge clk);
    #1 check("sm_drain_fill", fill_sm, 0);
    pulse_clear();
    #1 check("sm_ovf_cleared", ovf_sm, 0);

    // ---- 6: en dropped mid-slot -------------------------------------------
    q_sm.push_back(pack(0, 16'hD000));
    send_word(16'hD000, 1'b0, 16);
    check("sm_locked", locked_sm, 1);
    send_word(16'hD001, 1'b1, 8);
    en_sm = 0;
    send_bit(1'b1, 1'b1);
    check("sm_unlocked", locked_sm, 0);
    for (int b = 6; b >= 0; b--) send_bit(1'b1, 1'b1);
    en_sm = 1;
    q_sm.push_back(pack(0, 16'hD002));
    send_word(16'hD002, 1'b0, 16);
    q_sm.push_back(pack(1, 16'hD003));
    send_word(16'hD003, 1'b1, 16);
    idle(2, 1'b1);
    settle();
    check("sm_relocked", locked_sm, 1);
    check("sm_no_ferr", ferr_sm, 0);
    check("sm_sb_empty", q_sm.size(), 0);

    // ---- 7: asynchronous reset mid-word -----------------------------------
    ready_sm = 0;
    send_word(16'hE000, 1'b0, 16);
    send_word(16'hE001, 1'b1, 16);
    send_word(16'hE002, 1'b0, 5);
    settle();
    check("sm_fill_before_rst", fill_sm, 2);
    @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check("arst_valid", valid_sm, 0);
    check("arst_fill", fill_sm, 0);
    check("arst_locked", locked_sm, 0);
    check("arst_data", {chan_sm, data_sm}, 0);
    check("arst_flags", {ovf_sm, ferr_sm}, 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    settle();
    check("lj_final_empty", q_lj.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
